// File: rtl/count_pwm_if.sv
// Signal bundle between a counter-side driver and the count_pwm consumer.
interface count_pwm_if #(
   parameter int SIZE = 8
);
   logic [SIZE-1:0] count;
   logic            up_down;
   logic            duty_wr;
   logic [SIZE-1:0] duty_in;
   logic            pwm_en;
   logic            irq_clr;
   logic            pwm_out;
   logic            wrap_pulse;
   logic [SIZE-1:0] duty_active;
   logic            irq;

   modport master (
      output count, up_down, duty_wr, duty_in, pwm_en, irq_clr,
      input  pwm_out, wrap_pulse, duty_active, irq
   );

   modport slave (
      input  count, up_down, duty_wr, duty_in, pwm_en, irq_clr,
      output pwm_out, wrap_pulse, duty_active, irq
   );
endinterface

// File: rtl/count_pwm.sv
// Counter follower: detects terminal-count wrap, double-buffers the duty value
// so it only changes at wrap, and drives a registered PWM plus wrap pulse/irq.
module count_pwm #(
   parameter int SIZE = 8
) (
   input logic        clk,
   input logic        reset,
   count_pwm_if.slave bus
);
   localparam logic [SIZE-1:0] MAX = '1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state, state_nxt;
   logic            run;
   logic            wrap;
   logic [SIZE-1:0] count_p1;
   logic            dir_p1;
   logic [SIZE-1:0] duty_pend;
   logic            pend_vld;
   logic [SIZE-1:0] duty_active;
   logic            pwm_out;
   logic            wrap_pulse;
   logic            irq;

   // A wrap is only the single step across the terminal count in the sampled direction.
   function automatic logic is_wrap(input logic            dir,
                                    input logic [SIZE-1:0] prev,
                                    input logic [SIZE-1:0] cur);
      return (dir && prev == MAX && cur == '0) || (!dir && prev == '0 && cur == MAX);
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      run = (state == RUN);
   end

   assign wrap = run && is_wrap(dir_p1, count_p1, bus.count);

   // Stage p1: counter history for the next cycle's wrap test
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_p1 <= '0;
         dir_p1   <= 1'b0;
      end else begin
         count_p1 <= bus.count;
         dir_p1   <= bus.up_down;
      end
   end

   // A write landing on the wrap cycle becomes the next pending value; the old one transfers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         duty_pend   <= '0;
         pend_vld    <= 1'b0;
         duty_active <= '0;
      end else begin
         if (wrap && pend_vld) duty_active <= duty_pend;
         if (bus.duty_wr) begin
            duty_pend <= bus.duty_in;
            pend_vld  <= 1'b1;
         end else if (wrap && pend_vld) begin
            pend_vld  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_out    <= 1'b0;
         wrap_pulse <= 1'b0;
         irq        <= 1'b0;
      end else begin
         pwm_out    <= bus.pwm_en && (bus.count < duty_active);
         wrap_pulse <= wrap;
         if (wrap)             irq <= 1'b1;
         else if (bus.irq_clr) irq <= 1'b0;
      end
   end

   assign bus.pwm_out     = pwm_out;
   assign bus.wrap_pulse  = wrap_pulse;
   assign bus.duty_active = duty_active;
   assign bus.irq         = irq;
endmodule
